glyph_match_ctrl: RTL

Sequencer that shares the 16x16 glyph template ROMs between the recognition path and a captured input bitmap. On `start` it scans every template row by row, accumulates the per-glyph Hamming distance against the bitmap, and reports the closest glyph (digit or operator) with its distance. It sits between the capture buffer, the template ROM bank and the calculator/operator logic.

---
 rtl/glyph_pkg.sv | 27 ++
 rtl/row_popcount16.sv | 29 ++
 rtl/glyph_match_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/glyph_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : glyph_pkg
//  Description : Shared widths, constants and state encoding for the glyph
//                template matcher and its row popcount helper.
//  Revision    : 1.0  initial release
// ============================================================================
package glyph_pkg;

   localparam int GLYPH_W    = 16;  // pixels per template row
   localparam int GLYPH_ROWS = 16;  // rows per template
   localparam int DIST_W     = 9;   // Hamming distance 0..256
   localparam int GSEL_W     = 4;   // template select width
   localparam int ROW_AW     = 4;   // row address width
   localparam int CNT_W      = 5;   // per-row popcount 0..16

   // Initial running best: larger than nothing, equal to a fully inverted glyph
   localparam logic [DIST_W-1:0] DIST_MAX = 9'd256;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/row_popcount16.sv
`default_nettype none
// ============================================================================
//  Module      : row_popcount16
//  Description : Combinational XOR of two 16-pixel rows followed by a
//                popcount, giving the per-row Hamming distance (0..16).
//  Revision    : 1.0  initial release
// ============================================================================
module row_popcount16
   import glyph_pkg::*;
(
   input  logic [GLYPH_W-1:0] a,
   input  logic [GLYPH_W-1:0] b,
   output logic [CNT_W-1:0]   count
);

   logic [GLYPH_W-1:0] diff;

   assign diff = a ^ b;

   // Count differing pixels in the row
   always_comb begin
      count = '0;
      for (int i = 0; i < GLYPH_W; i++) begin
         count = count + CNT_W'(diff[i]);
      end
   end

endmodule
`default_nettype wire

// File: rtl/glyph_match_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : glyph_match_ctrl
//  Description : Scans NGLYPH 16x16 templates one row per cycle against a
//                captured bitmap, tracks the minimum Hamming distance and
//                reports the closest glyph, its distance and a match flag.
//  Revision    : 1.0  initial release
// ============================================================================
module glyph_match_ctrl
   import glyph_pkg::*;
#(
   parameter int NGLYPH      = 16,
   parameter int REJECT_DIST = 64
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                abort,
   output logic [GSEL_W-1:0]   glyph_sel,
   output logic [ROW_AW-1:0]   rom_addr,
   input  logic [GLYPH_W-1:0]  rom_row,
   output logic [ROW_AW-1:0]   bmp_addr,
   input  logic [GLYPH_W-1:0]  bmp_row,
   output logic                busy,
   output logic                done,
   output logic                valid,
   output logic [GSEL_W-1:0]   best_glyph,
   output logic [DIST_W-1:0]   best_dist,
   output logic                match
);

   localparam logic [GSEL_W-1:0] LAST_G = GSEL_W'(NGLYPH - 1);
   localparam logic [ROW_AW-1:0] LAST_R = ROW_AW'(GLYPH_ROWS - 1);
   localparam logic [DIST_W-1:0] REJ_D  = DIST_W'(REJECT_DIST);

   state_t             state;
   logic [GSEL_W-1:0]  g;
   logic [ROW_AW-1:0]  r;
   logic [DIST_W-1:0]  acc;
   logic [DIST_W-1:0]  run_best;
   logic [GSEL_W-1:0]  run_glyph;

   logic [CNT_W-1:0]   row_d;
   logic [DIST_W-1:0]  tot;
   logic               better;
   logic [DIST_W-1:0]  fin_dist;
   logic [GSEL_W-1:0]  fin_glyph;

   row_popcount16 u_popcount (
      .a     (rom_row),
      .b     (bmp_row),
      .count (row_d)
   );

   // Glyph total including the current row; strict compare keeps the lower
   // index on a tie. fin_* is the winner once the last row has been added.
   assign tot       = acc + DIST_W'(row_d);
   assign better    = (tot < run_best);
   assign fin_dist  = better ? tot : run_best;
   assign fin_glyph = better ? g   : run_glyph;

   // Addresses come straight from the counters, which are zero outside SCAN
   assign glyph_sel = g;
   assign rom_addr  = r;
   assign bmp_addr  = r;

   // Scan sequencer with registered status and result outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         g          <= '0;
         r          <= '0;
         acc        <= '0;
         run_best   <= DIST_MAX;
         run_glyph  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         valid      <= 1'b0;
         best_glyph <= '0;
         best_dist  <= '0;
         match      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !abort) begin
                  state     <= SCAN;
                  g         <= '0;
                  r         <= '0;
                  acc       <= '0;
                  run_best  <= DIST_MAX;
                  run_glyph <= '0;
                  valid     <= 1'b0;
                  busy      <= 1'b1;
               end
            end
            SCAN: begin
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  g     <= '0;
                  r     <= '0;
                  acc   <= '0;
               end else if (r != LAST_R) begin
                  acc <= tot;
                  r   <= r + 1'b1;
               end else begin
                  run_best  <= fin_dist;
                  run_glyph <= fin_glyph;
                  acc       <= '0;
                  r         <= '0;
                  if (g != LAST_G) begin
                     g <= g + 1'b1;
                  end else begin
                     // Results land together with entry to DONE so they are
                     // valid in the done cycle itself
                     state      <= DONE;
                     busy       <= 1'b0;
                     g          <= '0;
                     best_glyph <= fin_glyph;
                     best_dist  <= fin_dist;
                     match      <= (fin_dist <= REJ_D);
                     valid      <= 1'b1;
                     done       <= 1'b1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
